// File: rtl/matrix_alu_pkg.sv
// Shared opcodes, FSM state type and result-width helper for the NxN matrix ALU.
package matrix_alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_MUL   = 3'd2;
    localparam logic [2:0] OP_TRANS = 3'd3;
    localparam logic [2:0] OP_DET   = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Signed result element width: product plus log2(N) sum growth plus sign.
    function automatic int unsigned rw_calc(input int unsigned w, input int unsigned n);
        return 2 * w + 32'($clog2(n)) + 1;
    endfunction

endpackage

// File: rtl/matrix_alu_nxn_if.sv
// Operand/result valid-ready bus between the operand source, the matrix ALU and the consumer.
interface matrix_alu_nxn_if #(
    parameter int unsigned W = 4,
    parameter int unsigned N = 2
);
    localparam int unsigned RW = matrix_alu_pkg::rw_calc(W, N);

    logic                in_valid;
    logic                in_ready;
    logic [2:0]          op;
    logic [N*N*W-1:0]    a;
    logic [N*N*W-1:0]    b;
    logic                out_valid;
    logic                out_ready;
    logic [N*N*RW-1:0]   c;
    logic                err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, c, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, c, err
    );

endinterface

// File: rtl/matrix_mac.sv
// Shared W x W unsigned multiplier feeding a signed RW-bit add/subtract accumulator.
module matrix_mac
    import matrix_alu_pkg::*;
#(
    parameter  int unsigned W  = 4,
    parameter  int unsigned N  = 2,
    localparam int unsigned RW = rw_calc(W, N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_clr,
    input  logic          i_sub,
    input  logic [W-1:0]  i_x,
    input  logic [W-1:0]  i_y,
    output logic [RW-1:0] o_sum_c
);
    localparam int unsigned PW = 2 * W;

    logic [RW-1:0] r_acc;
    logic [RW-1:0] w_base;
    logic [RW-1:0] w_prod_x;
    logic [PW-1:0] w_prod;

    // Clear folds into the current cycle so the first product needs no extra step.
    assign w_prod   = PW'(i_x) * PW'(i_y);
    assign w_prod_x = RW'(w_prod);
    assign w_base   = i_clr ? '0 : r_acc;
    assign o_sum_c  = i_sub ? (w_base - w_prod_x) : (w_base + w_prod_x);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_sum_c;
        end
    end

endmodule

// File: rtl/matrix_alu_nxn.sv
// Sequential NxN matrix engine: add/sub/transpose in one step, multiply/determinant via one shared MAC.
module matrix_alu_nxn
    import matrix_alu_pkg::*;
#(
    parameter int unsigned W = 4,
    parameter int unsigned N = 2
) (
    input  logic            clk,
    input  logic            rst,
    matrix_alu_nxn_if.slave bus
);
    localparam int unsigned RW     = rw_calc(W, N);
    localparam int unsigned NE     = N * N;
    localparam int unsigned CW     = $clog2(N);
    localparam bit          DET_OK = (N == 2);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NE*W-1:0]   r_a;
    logic [NE*W-1:0]   r_b;
    logic [2:0]        r_op;
    logic [CW-1:0]     r_i;
    logic [CW-1:0]     r_j;
    logic [CW-1:0]     r_k;
    logic [NE*RW-1:0]  r_c;
    logic [NE*RW-1:0]  w_c_imm;
    logic              r_err;
    logic              r_out_valid;
    logic              r_in_ready;
    logic              w_accept;
    logic              w_err_in;
    logic              w_direct;
    logic              w_en;
    logic              w_clr;
    logic              w_sub;
    logic              w_wr;
    logic              w_last;
    logic [W-1:0]      w_mx;
    logic [W-1:0]      w_my;
    logic [RW-1:0]     w_sum;
    int unsigned       w_wr_idx;

    function automatic logic [W-1:0] el(input logic [NE*W-1:0] m,
                                        input int unsigned row,
                                        input int unsigned col);
        return m[(NE - 1 - (row * N + col)) * W +: W];
    endfunction

    // Next-state logic; single-step ops and errors skip the MAC phase.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = bus.in_valid && r_in_ready;
        w_err_in    = (bus.op > OP_DET) || ((bus.op == OP_DET) && !DET_OK);
        w_direct    = w_err_in || (bus.op == OP_ADD) || (bus.op == OP_SUB) ||
                      (bus.op == OP_TRANS);
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = w_direct ? DONE : MAC;
            MAC:     if (w_last) w_state_nxt = DONE;
            DONE:    if (bus.out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Element-wise results computed straight from the bus on the accept cycle.
    always_comb begin
        w_c_imm = '0;
        if (!w_err_in) begin
            for (int unsigned i = 0; i < N; i++) begin
                for (int unsigned j = 0; j < N; j++) begin
                    case (bus.op)
                        OP_ADD:   w_c_imm[(NE-1-(i*N+j))*RW +: RW] =
                                      RW'(el(bus.a, i, j)) + RW'(el(bus.b, i, j));
                        OP_SUB:   w_c_imm[(NE-1-(i*N+j))*RW +: RW] =
                                      RW'(el(bus.a, i, j)) - RW'(el(bus.b, i, j));
                        OP_TRANS: w_c_imm[(NE-1-(i*N+j))*RW +: RW] =
                                      RW'(el(bus.a, j, i));
                        default:  ;
                    endcase
                end
            end
        end
    end

    // MAC operand steering: DET uses k as its two-step sequencer.
    always_comb begin
        w_en     = 1'b0;
        w_clr    = 1'b0;
        w_sub    = 1'b0;
        w_wr     = 1'b0;
        w_last   = 1'b0;
        w_mx     = '0;
        w_my     = '0;
        w_wr_idx = 32'(r_i) * N + 32'(r_j);
        if (r_state == MAC) begin
            w_en  = 1'b1;
            w_clr = (r_k == '0);
            if (r_op == OP_DET) begin
                w_sub  = (r_k != '0);
                w_mx   = (r_k == '0) ? el(r_a, 0, 0) : el(r_a, 0, 1);
                w_my   = (r_k == '0) ? el(r_a, 1, 1) : el(r_a, 1, 0);
                w_wr   = (r_k != '0);
                w_last = w_wr;
            end else begin
                w_mx   = el(r_a, 32'(r_i), 32'(r_k));
                w_my   = el(r_b, 32'(r_k), 32'(r_j));
                w_wr   = (r_k == CW'(N - 1));
                w_last = w_wr && (r_i == CW'(N - 1)) && (r_j == CW'(N - 1));
            end
        end
    end

    matrix_mac #(
        .W (W),
        .N (N)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_en),
        .i_clr   (w_clr),
        .i_sub   (w_sub),
        .i_x     (w_mx),
        .i_y     (w_my),
        .o_sum_c (w_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, counters, result register and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_c         <= '0;
            r_err       <= 1'b0;
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            r_out_valid <= (w_state_nxt == DONE);
            r_in_ready  <= (w_state_nxt == IDLE);
            if (w_accept) begin
                r_a   <= bus.a;
                r_b   <= bus.b;
                r_op  <= bus.op;
                r_c   <= w_c_imm;
                r_err <= w_err_in;
                r_i   <= '0;
                r_j   <= '0;
                r_k   <= '0;
            end else if (r_state == MAC) begin
                if (w_wr) begin
                    r_c[(NE - 1 - w_wr_idx) * RW +: RW] <= w_sum;
                end
                if (r_k == CW'(N - 1)) begin
                    r_k <= '0;
                    if (r_j == CW'(N - 1)) begin
                        r_j <= '0;
                        r_i <= r_i + 1'b1;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end else begin
                    r_k <= r_k + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.c         = r_c;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_matrix_alu_nxn.sv
// Directed bench for matrix_alu_nxn at N=2 and N=3 with a reference model feeding a result scoreboard.
module tb_matrix_alu_nxn;
    import matrix_alu_pkg::*;

    localparam int unsigned W = 4;

    typedef struct {
        logic [127:0] c;
        logic         err;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    matrix_alu_nxn_if #(.W(W), .N(2)) if2 ();
    matrix_alu_nxn_if #(.W(W), .N(3)) if3 ();

    matrix_alu_nxn #(.W(W), .N(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    matrix_alu_nxn #(.W(W), .N(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    initial begin
        #500000;
        $display("FAIL watchdog expired before end of run");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] get_c(input int sel);
        return (sel == 2) ? 128'(if2.c) : 128'(if3.c);
    endfunction

    function automatic logic get_ov(input int sel);
        return (sel == 2) ? if2.out_valid : if3.out_valid;
    endfunction

    function automatic logic get_ir(input int sel);
        return (sel == 2) ? if2.in_ready : if3.in_ready;
    endfunction

    function automatic logic get_err(input int sel);
        return (sel == 2) ? if2.err : if3.err;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [2:0] op,
                         input logic [127:0] a, input logic [127:0] b);
        if (sel == 2) begin
            if2.in_valid = v; if2.op = op; if2.a = 16'(a); if2.b = 16'(b);
        end else begin
            if3.in_valid = v; if3.op = op; if3.a = 36'(a); if3.b = 36'(b);
        end
    endtask

    task automatic set_ordy(input int sel, input logic r);
        if (sel == 2) if2.out_ready = r;
        else          if3.out_ready = r;
    endtask

    // Reference: plain integer matrix arithmetic, packed MSB-first at the result width.
    function automatic void model(input int n, input logic [2:0] op,
                                  input logic [127:0] a, input logic [127:0] b,
                                  output logic [127:0] c, output logic err, output int lat);
        int ea[3][3];
        int eb[3][3];
        int r[3][3];
        int rw;
        logic [127:0] mask;
        rw   = 2 * int'(W) + $clog2(n) + 1;
        mask = (128'(1) << rw) - 128'(1);
        err  = 1'b0;
        lat  = 1;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                ea[i][j] = int'(a[(n*n-1-(i*n+j))*W +: W]);
                eb[i][j] = int'(b[(n*n-1-(i*n+j))*W +: W]);
                r[i][j]  = 0;
            end
        end
        case (op)
            3'd0: for (int i = 0; i < n; i++) for (int j = 0; j < n; j++) r[i][j] = ea[i][j] + eb[i][j];
            3'd1: for (int i = 0; i < n; i++) for (int j = 0; j < n; j++) r[i][j] = ea[i][j] - eb[i][j];
            3'd2: begin
                for (int i = 0; i < n; i++)
                    for (int j = 0; j < n; j++)
                        for (int k = 0; k < n; k++) r[i][j] += ea[i][k] * eb[k][j];
                lat = n * n * n + 1;
            end
            3'd3: for (int i = 0; i < n; i++) for (int j = 0; j < n; j++) r[i][j] = ea[j][i];
            3'd4: begin
                if (n == 2) begin
                    r[0][0] = ea[0][0] * ea[1][1] - ea[0][1] * ea[1][0];
                    lat = 3;
                end else begin
                    err = 1'b1;
                end
            end
            default: err = 1'b1;
        endcase
        c = '0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                c = (c << rw) | (128'(r[i][j]) & mask);
    endfunction

    // One full transaction: accept, wait for result, optional stall, then drain.
    task automatic run_op(input string tag, input int sel, input logic [2:0] op,
                          input logic [127:0] a, input logic [127:0] b,
                          input int stall, output logic [127:0] got_c);
        exp_t e;
        exp_t x;
        int   lat;
        model(sel, op, a, b, e.c, e.err, e.lat);
        sb.push_back(e);
        @(negedge clk);
        chk({tag, ":in_ready_idle"}, 128'(get_ir(sel)), 128'(1));
        drive(sel, 1'b1, op, a, b);
        @(posedge clk); #1;
        drive(sel, 1'b0, ~op, ~a, ~b);
        lat = 1;
        while (get_ov(sel) !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        x = sb.pop_front();
        chk({tag, ":out_valid"}, 128'(get_ov(sel)), 128'(1));
        chk({tag, ":latency"},   128'(lat),         128'(x.lat));
        chk({tag, ":c"},         get_c(sel),        x.c);
        chk({tag, ":err"},       128'(get_err(sel)), 128'(x.err));
        got_c = get_c(sel);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk({tag, ":stall_c"},        get_c(sel),        x.c);
            chk({tag, ":stall_valid"},    128'(get_ov(sel)), 128'(1));
            chk({tag, ":stall_in_ready"}, 128'(get_ir(sel)), 128'(0));
        end
        set_ordy(sel, 1'b1);
        @(posedge clk); #1;
        set_ordy(sel, 1'b0);
        chk({tag, ":drained_valid"}, 128'(get_ov(sel)), 128'(0));
        chk({tag, ":ready_again"},   128'(get_ir(sel)), 128'(1));
    endtask

    initial begin
        logic [127:0] got;
        int           seen;
        rst = 1'b1;
        drive(2, 1'b0, 3'd0, '0, '0);
        drive(3, 1'b0, 3'd0, '0, '0);
        set_ordy(2, 1'b0);
        set_ordy(3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst:in_ready2",  128'(if2.in_ready),  128'(0));
        chk("rst:out_valid2", 128'(if2.out_valid), 128'(0));
        chk("rst:err2",       128'(if2.err),       128'(0));
        chk("rst:c2",         get_c(2),            128'(0));
        chk("rst:c3",         get_c(3),            128'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst:in_ready_after2", 128'(if2.in_ready), 128'(1));
        chk("rst:in_ready_after3", 128'(if3.in_ready), 128'(1));

        // out_ready with nothing to deliver must not disturb anything.
        set_ordy(2, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        set_ordy(2, 1'b0);
        chk("idle_ordy:out_valid", 128'(if2.out_valid), 128'(0));
        chk("idle_ordy:in_ready",  128'(if2.in_ready),  128'(1));

        run_op("add", 2, OP_ADD, 128'h3214, 128'h1111, 0, got);
        chk("add:const", got, 128'({10'd4, 10'd3, 10'd2, 10'd5}));

        run_op("sub_stall", 2, OP_SUB, 128'h0214, 128'h1111, 5, got);
        chk("sub:c00_all_ones", 128'(got[39:30]), 128'(10'h3FF));

        run_op("mul2", 2, OP_MUL, 128'h3214, 128'h1111, 0, got);
        chk("mul2:const", got, 128'({4{10'd5}}));

        run_op("mul3_identity", 3, OP_MUL, 128'h123456789, 128'h100010001, 0, got);
        chk("mul3:equals_a", got, 128'({11'd1, 11'd2, 11'd3, 11'd4, 11'd5, 11'd6, 11'd7, 11'd8, 11'd9}));

        run_op("det_a", 2, OP_DET, 128'h1234, 128'h0, 0, got);
        chk("det_a:c00", 128'(got[39:30]), 128'(10'h3FE));
        chk("det_a:rest_zero", 128'(got[29:0]), 128'(0));

        run_op("det_b", 2, OP_DET, 128'h0321, 128'hFFFF, 1, got);
        chk("det_b:c00", 128'(got[39:30]), 128'(10'h3FA));

        run_op("trans2", 2, OP_TRANS, 128'h1234, 128'h0, 0, got);
        chk("trans2:const", got, 128'({10'd1, 10'd3, 10'd2, 10'd4}));

        run_op("illegal_op7", 2, 3'd7, 128'hFFFF, 128'hFFFF, 0, got);
        run_op("det_n3_err", 3, OP_DET, 128'h123456789, 128'h0, 0, got);
        run_op("trans3", 3, OP_TRANS, 128'h123456789, 128'h0, 0, got);

        // Abort a multiply mid-flight and confirm it never surfaces.
        @(negedge clk);
        drive(2, 1'b1, OP_MUL, 128'h3214, 128'h1111);
        @(posedge clk); #1;
        drive(2, 1'b0, OP_ADD, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort:busy_in_ready", 128'(if2.in_ready), 128'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort:out_valid", 128'(if2.out_valid), 128'(0));
        chk("abort:c",         get_c(2),            128'(0));
        chk("abort:in_ready",  128'(if2.in_ready),  128'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort:in_ready_after", 128'(if2.in_ready), 128'(1));
        seen = 0;
        set_ordy(2, 1'b1);
        repeat (12) begin
            @(posedge clk); #1;
            if (if2.out_valid === 1'b1) seen++;
        end
        set_ordy(2, 1'b0);
        chk("abort:never_presented", 128'(seen), 128'(0));
        run_op("post_abort_add", 2, OP_ADD, 128'h9876, 128'h1234, 0, got);

        for (int t = 0; t < 8; t++) begin
            run_op("rnd2", 2, 3'(t % 5), 128'($urandom), 128'($urandom), t % 3, got);
        end
        for (int t = 0; t < 5; t++) begin
            run_op("rnd3", 3, 3'(t), {64'h0, $urandom, $urandom}, {64'h0, $urandom, $urandom}, 0, got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_alu_nxn.md
# matrix_alu_nxn

Sequential, parametrised successor to the fixed-size 2x2 combinational matrix operators (add, subtract, multiply, transpose, determinant). The block accepts two packed NxN matrices of W-bit unsigned elements and an opcode over a valid/ready handshake. It computes the result through a single shared multiply-accumulate unit and returns a packed signed result matrix over a second valid/ready handshake. It sits between the operand source and the result consumer as the datapath's only matrix engine.

## Interface
- W, default 4: element width of the unsigned operands.
- N, default 2: matrix dimension, with N >= 2.
- RW, derived as 2*W + $clog2(N) + 1: width of each signed result element. Not overridable.
- clk, input, 1: clock.
- rst, input, 1: synchronous active-high reset.
- in_valid, input, 1: operands and opcode are valid.
- in_ready, output, 1: block is ready to accept operands; high only in IDLE.
- op, input, 3: operation select.
- a, input, N*N*W: matrix A, row-major. Element (0,0) occupies the MSBs; element (i,j) sits at index i*N+j counted from the MSB end.
- b, input, N*N*W: matrix B, with the same packing as a.
- out_valid, output, 1: result is valid.
- out_ready, input, 1: consumer accepts the result.
- c, output, N*N*RW: result matrix, with the same packing, each element a signed RW-bit value.
- err, output, 1: the result is invalid because of an illegal opcode or an unsupported operation. Qualified by out_valid.

## Operation
- Opcodes are fixed as follows:
  - ADD = 0: c = a + b.
  - SUB = 1: c = a - b, two's complement.
  - MUL = 2: c = a x b.
  - TRANS = 3: c(i,j) = a(j,i).
  - DET = 4: c(0,0) = a00*a11 - a01*a10; all other elements are 0. Legal only when N = 2.
  - Opcodes 5-7 are illegal.
- Handshake
  - A transfer occurs when in_valid && in_ready. a, b and op are latched on that cycle; input changes afterwards are ignored.
  - The result transfers when out_valid && out_ready.
  - c, err and out_valid hold stable until that transfer completes.
- State machine
  - IDLE: in_ready = 1. On accept, ADD/SUB/TRANS/illegal go to DONE and MUL/DET go to MAC.
  - MAC: one MAC per cycle using the i,j,k counters.
    - MUL takes N^3 cycles. The accumulator clears at k = 0 and is written to c(i,j) at k = N-1.
    - DET takes 2 cycles: +a00*a11, then -a01*a10.
    - The last MAC cycle goes to DONE.
  - DONE: out_valid = 1. Returns to IDLE on out_ready.
- Width rules
  - Operands are zero-extended to RW bits.
  - All results are exact. No overflow is possible at RW.
- Error cases: an illegal op, or DET with N != 2, produces err = 1 with c = 0 and DONE latency 1.

## Timing
- Reset values: in_ready = 0 during the reset cycle and 1 on the cycle after reset deasserts. out_valid = 0, err = 0, c = 0. State is IDLE and all counters are 0.
- Latency is measured from the accept edge (cycle 0) to the first cycle with out_valid high:
  - ADD, SUB, TRANS and error cases: 1 cycle.
  - DET: 3 cycles.
  - MUL: N^3 + 1 cycles.
- Throughput is one operation in flight. in_ready is 0 from the cycle after accept until the result transfers.
- in_ready returns to 1 on the cycle after the out_ready transfer. There is no same-cycle turnaround.
- Reset in MAC or DONE aborts the operation on the next edge. The aborted result is never presented, and all outputs take their reset values.
- out_ready high while out_valid is low has no effect.

## Structure
- Package matrix_alu_pkg holds:
  - the opcode localparams OP_ADD through OP_DET;
  - the state enum IDLE / MAC / DONE;
  - an RW helper function.
- Sub-module matrix_mac: a W x W unsigned multiplier with an add/subtract select and a signed RW-bit accumulator, with clear and enable inputs. It is instantiated once.
- Top level holds the FSM, the i/j/k counters, the operand registers, the result register and the output packing.

## Test plan
- ADD, W=4, N=2: a=[3 2;1 4], b=[1 1;1 1] -> c=[4 3;2 5], err=0, out_valid at cycle 1.
- SUB, W=4, N=2, with out_ready low for 5 cycles:
  - a=[0 2;1 4], b=[1 1;1 1] -> c=[-1 1;0 3] (c00 = all ones in RW bits).
  - c stays stable and in_ready stays 0 throughout the stall.
- MUL, W=4, N=2: a=[3 2;1 4], b=[1 1;1 1] -> c=[5 5;5 5], out_valid at cycle 9. With N=3, A times the identity -> c = A at cycle 28.
- DET, W=4, N=2:
  - a=[1 2;3 4] -> c00=-2, other elements 0, out_valid at cycle 3.
  - a=[0 3;2 1] -> c00=-6.
- Error cases: op=7 -> err=1, c=0, out_valid at cycle 1. DET with N=3 -> err=1.
- Reset mid-operation: rst asserted during MUL cycle 4 -> on the next edge out_valid=0, c=0, and in_ready returns to 1 after rst deasserts. A following ADD completes correctly.
